// File: rtl/mem_stage_if.sv
// EX/MEM-to-MEM/WB bus for the MEM stage: the upstream latch contents in,
// the branch decision, the stall and the MEM/WB latch out.
interface mem_stage_if;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2out;
    logic [4:0]  five_bit_muxout;
    logic        pcsrc;
    logic        mem_stall;
    logic [1:0]  mem_wb_ctl;
    logic [31:0] read_data;
    logic [31:0] mem_alu_result;
    logic [4:0]  mem_write_reg;

    modport master (
        output wb_ctlout, m_ctlout, zero, alu_result, rdata2out, five_bit_muxout,
        input  pcsrc, mem_stall, mem_wb_ctl, read_data, mem_alu_result, mem_write_reg
    );

    modport slave (
        input  wb_ctlout, m_ctlout, zero, alu_result, rdata2out, five_bit_muxout,
        output pcsrc, mem_stall, mem_wb_ctl, read_data, mem_alu_result, mem_write_reg
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: word-addressed data memory with MEM_LAT-cycle accesses,
// branch decision, and the MEM/WB latch. Stalls upstream while BUSY.
module mem_stage #(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8,
    parameter int MEM_LAT   = 1
) (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave bus
);
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t r_state, w_next;
    logic [3:0] r_cnt;

    // Access operands captured on entry to BUSY; upstream changes are ignored after that.
    logic [ADDR_BITS-1:0] r_cap_idx;
    logic [31:0]          r_cap_wdata;
    logic                 r_cap_rd, r_cap_wr;
    logic [1:0]           r_cap_wb;
    logic [31:0]          r_cap_alu;
    logic [4:0]           r_cap_wreg;

    logic [31:0] r_mem [DEPTH];

    logic [1:0]  r_mem_wb_ctl;
    logic [31:0] r_read_data;
    logic [31:0] r_mem_alu_result;
    logic [4:0]  r_mem_write_reg;

    logic                 w_req;
    logic                 w_stall, w_done, w_bubble;
    logic [ADDR_BITS-1:0] w_idx;
    logic [31:0]          w_wdata;
    logic                 w_rd, w_wr;
    logic [1:0]           w_wb;
    logic [31:0]          w_alu;
    logic [4:0]           w_wreg;

    assign w_req = bus.m_ctlout[1] | bus.m_ctlout[0];

    // Operand source: live inputs in IDLE, captured copy in BUSY.
    always_comb begin
        if (r_state == S_BUSY) begin
            w_idx   = r_cap_idx;
            w_wdata = r_cap_wdata;
            w_rd    = r_cap_rd;
            w_wr    = r_cap_wr;
            w_wb    = r_cap_wb;
            w_alu   = r_cap_alu;
            w_wreg  = r_cap_wreg;
        end else begin
            w_idx   = bus.alu_result[ADDR_BITS+1:2];
            w_wdata = bus.rdata2out;
            w_rd    = bus.m_ctlout[1];
            w_wr    = bus.m_ctlout[0];
            w_wb    = bus.wb_ctlout;
            w_alu   = bus.alu_result;
            w_wreg  = bus.five_bit_muxout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req && MEM_LAT > 1) w_next = S_BUSY;
            S_BUSY: if (r_cnt == 4'd1)        w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_stall  = 1'b0;
        w_done   = 1'b0;
        w_bubble = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (MEM_LAT > 1) begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                w_stall  = (r_cnt != 4'd1);
                w_done   = (r_cnt == 4'd1);
                w_bubble = (r_cnt != 4'd1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_cap_idx   <= '0;
            r_cap_wdata <= '0;
            r_cap_rd    <= 1'b0;
            r_cap_wr    <= 1'b0;
            r_cap_wb    <= '0;
            r_cap_alu   <= '0;
            r_cap_wreg  <= '0;
        end else if (r_state == S_IDLE && w_next == S_BUSY) begin
            r_cnt       <= LAT_M1;
            r_cap_idx   <= w_idx;
            r_cap_wdata <= w_wdata;
            r_cap_rd    <= w_rd;
            r_cap_wr    <= w_wr;
            r_cap_wb    <= w_wb;
            r_cap_alu   <= w_alu;
            r_cap_wreg  <= w_wreg;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Read uses the pre-edge contents, so a combined read+write returns old data.
    always_ff @(posedge clk) begin
        if (!rst && w_done && w_wr) r_mem[w_idx] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_wb_ctl     <= '0;
            r_read_data      <= '0;
            r_mem_alu_result <= '0;
            r_mem_write_reg  <= '0;
        end else if (w_bubble) begin
            r_mem_wb_ctl <= '0;
        end else begin
            r_mem_wb_ctl     <= w_wb;
            r_read_data      <= (w_done && w_rd) ? r_mem[w_idx] : 32'd0;
            r_mem_alu_result <= w_alu;
            r_mem_write_reg  <= w_wreg;
        end
    end

    assign bus.pcsrc          = bus.m_ctlout[2] & bus.zero;
    assign bus.mem_stall      = w_stall;
    assign bus.mem_wb_ctl     = r_mem_wb_ctl;
    assign bus.read_data      = r_read_data;
    assign bus.mem_alu_result = r_mem_alu_result;
    assign bus.mem_write_reg  = r_mem_write_reg;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. It sits directly downstream of the EX/MEM latch and consumes that latch's outputs.
- Contains a word-addressed data memory with configurable access latency, the branch decision (pcsrc), and the MEM/WB pipeline latch feeding write-back.
- Raises mem_stall to freeze the upstream stages while a multi-cycle memory access is in flight.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory (power of two).
- ADDR_BITS, 8, log2(DEPTH).
- MEM_LAT, 1, cycles per load/store access (1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- wb_ctlout  input  2  WB controls from EX/MEM: [1]=RegWrite, [0]=MemtoReg.
- m_ctlout  input  3  MEM controls: [2]=Branch, [1]=MemRead, [0]=MemWrite.
- zero  input  1  ALU zero flag.
- alu_result  input  32  ALU result; also the byte address for data memory.
- rdata2out  input  32  store data.
- five_bit_muxout  input  5  destination register number.
- pcsrc  output  1  branch taken, to the IF PC mux.
- mem_stall  output  1  high while an access is incomplete; upstream holds.
- mem_wb_ctl  output  2  registered WB controls.
- read_data  output  32  registered load data.
- mem_alu_result  output  32  registered ALU result.
- mem_write_reg  output  5  registered destination register.

Behaviour:
- Reset, sampled on clk: mem_wb_ctl=0, read_data=0, mem_alu_result=0, mem_write_reg=0, FSM=IDLE, cnt=0. Any pending store is aborted and never written. Memory contents are not reset.
- pcsrc = m_ctlout[2] & zero, purely combinational. It is never masked by stall, because branches make no memory access.
- Address: word index = alu_result[ADDR_BITS+1:2]. Bits [1:0] are ignored. Upper bits are truncated, so addresses wrap modulo DEPTH words.
- req = m_ctlout[1] | m_ctlout[0].
- FSM states are IDLE and BUSY; cnt is 4 bits.
  - IDLE, req=0: no access. MEM/WB latch loads the inputs every edge. read_data loads 0.
  - IDLE, req=1, MEM_LAT=1: the access completes at this edge. No stall.
  - IDLE, req=1, MEM_LAT>1: mem_stall=1 combinationally. At the edge: go to BUSY, cnt=MEM_LAT-1. MEM/WB loads a bubble.
  - BUSY: mem_stall = (cnt!=1). Each edge decrements cnt. When cnt==1, the access completes at that edge and the FSM returns to IDLE.
  - Net effect: a request is stalled for exactly MEM_LAT-1 cycles and completes on the MEM_LAT-th edge after it is first presented.
- Bubble: mem_wb_ctl=0. read_data, mem_alu_result and mem_write_reg hold their previous values.
- Completion edge:
  - MemWrite: mem[idx] <= rdata2out, written exactly once per request.
  - MemRead: read_data <= mem[idx].
  - MEM/WB loads wb_ctlout, alu_result and five_bit_muxout.
- MemRead and MemWrite both set: the write is performed and read_data returns the pre-write contents.
- Upstream must hold all inputs constant while mem_stall=1. Input changes during BUSY are ignored, because address and data are captured at entry to BUSY.
- Reset during BUSY: back to IDLE, no memory write, mem_stall=0 in the following cycle.
- Back-to-back requests: a new request presented in the cycle after completion starts a fresh access with no idle gap.

Test Plan:
1. rst=1 for 2 cycles with nonzero inputs -> all registered outputs 0, mem_stall=0.
2. MEM_LAT=1 load/store:
   - Store: m_ctlout=3'b001, alu_result=0x10, rdata2out=0xDEADBEEF.
   - Then load: m_ctlout=3'b010, alu_result=0x13, wb_ctlout=2'b11, five_bit_muxout=7.
   - Required: one edge later read_data=0xDEADBEEF (low bits ignored), mem_wb_ctl=2'b11, mem_write_reg=7, no stall at any point.
3. MEM_LAT=4 load:
   - mem_stall high for exactly 3 cycles, and mem_wb_ctl=0 during those cycles.
   - The 4th edge delivers the data.
   - A store under MEM_LAT=4 updates memory only once; verify with a subsequent load.
4. Branch: m_ctlout=3'b100 with zero=1 -> pcsrc=1 in the same cycle. zero=0 -> pcsrc=0. mem_stall stays 0 in both cases.
5. Wrap, with DEPTH=256:
   - Store 0x1234 to address 0x400, which is index 0 after truncation.
   - Load from address 0x0 -> read_data=0x1234.
6. Reset mid-access, MEM_LAT=4:
   - Assert rst in the 2nd BUSY cycle of a store of 0xAAAA to 0x20.
   - Required: FSM returns to IDLE, a later load of 0x20 returns the old contents, and mem_stall drops the cycle after reset.
